// File: rtl/route_table_ctrl.sv
// rtl/route_table_ctrl.sv - routing-table memory, host write handshake and router reset sequencing
// Optional feature macro: ROUTE_TABLE_DEFAULT_EN (INIT sweep loads addr mod PORTS into every entry)
module route_table_ctrl #(
  parameter int PORTS         = 5,
  parameter int PORT_BITS     = 8,
  parameter int DEST_BITS     = 7,
  parameter int RELOAD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_req,
  output logic                 cfg_ack,
  input  logic [DEST_BITS-1:0] cfg_addr,
  input  logic [PORT_BITS-1:0] cfg_data,
  input  logic                 cfg_last,
  input  logic [DEST_BITS-1:0] table_addr,
  output logic [PORT_BITS-1:0] table_data,
  output logic                 router_reset,
  output logic                 busy,
  output logic                 err
);

  localparam int DESTS   = 2 ** DEST_BITS;
  localparam int RC_BITS = $clog2(RELOAD_CYCLES + 1);
  localparam logic [PORT_BITS-1:0] PORTS_LIM = PORT_BITS'(PORTS);

  typedef enum logic [2:0] {
    S_INIT,
    S_PROG,
    S_ACK,
    S_RELOAD,
    S_RUN
  } state_t;

  state_t               state;
  logic [PORT_BITS-1:0] mem [DESTS];
  logic                 last_q;
  logic                 from_run;
  logic [RC_BITS-1:0]   reload_cnt;
  logic                 accept;
  logic                 legal;
  logic                 mem_we;
  logic [DEST_BITS-1:0] mem_waddr;
  logic [PORT_BITS-1:0] mem_wdata;
`ifdef ROUTE_TABLE_DEFAULT_EN
  logic [DEST_BITS-1:0] sweep_cnt;
`endif

  // A new write is taken only in PROG/RUN and only once per req level (ack still low)
  assign accept = ((state == S_PROG) || (state == S_RUN)) && cfg_req && !cfg_ack;
  assign legal  = (cfg_data < PORTS_LIM);

  // Router preload reads are served with zero latency
  assign table_data = mem[table_addr];

  // Single memory write port: host writes, plus the default sweep when enabled
  always_comb begin
    mem_we    = accept && legal;
    mem_waddr = cfg_addr;
    mem_wdata = cfg_data;
`ifdef ROUTE_TABLE_DEFAULT_EN
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_cnt;
      mem_wdata = PORT_BITS'(32'(sweep_cnt) % PORTS);
    end
`endif
  end

  // Table storage, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DESTS; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM with registered handshake, router reset, busy and sticky error outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_INIT;
      cfg_ack      <= 1'b0;
      router_reset <= 1'b1;
      busy         <= 1'b1;
      err          <= 1'b0;
      last_q       <= 1'b0;
      from_run     <= 1'b0;
      reload_cnt   <= '0;
`ifdef ROUTE_TABLE_DEFAULT_EN
      sweep_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_INIT: begin
`ifdef ROUTE_TABLE_DEFAULT_EN
          sweep_cnt <= sweep_cnt + 1'b1;
          if (&sweep_cnt) begin
            state <= S_PROG;
          end
`else
          state <= S_PROG;
`endif
        end
        S_PROG, S_RUN: begin
          if (accept) begin
            if (!legal) begin
              err <= 1'b1;
            end
            last_q   <= cfg_last;
            from_run <= (state == S_RUN);
            cfg_ack  <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          if (!cfg_req) begin
            cfg_ack <= 1'b0;
            if (last_q && !from_run) begin
              router_reset <= 1'b0;
              busy         <= 1'b0;
              state        <= S_RUN;
            end else if (last_q) begin
              router_reset <= 1'b1;
              reload_cnt   <= RC_BITS'(RELOAD_CYCLES - 1);
              state        <= S_RELOAD;
            end else if (from_run) begin
              busy  <= 1'b0;
              state <= S_RUN;
            end else begin
              state <= S_PROG;
            end
          end
        end
        S_RELOAD: begin
          if (reload_cnt == '0) begin
            router_reset <= 1'b0;
            busy         <= 1'b0;
            state        <= S_RUN;
          end else begin
            reload_cnt <= reload_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_route_table_ctrl.sv
// tb/tb_route_table_ctrl.sv - self-checking bench for route_table_ctrl
module tb_route_table_ctrl;

`ifdef ROUTE_TABLE_DEFAULT_EN
  localparam int INIT_CYC = 128;
`else
  localparam int INIT_CYC = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_req;
  logic       cfg_ack;
  logic [6:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic [6:0] table_addr;
  logic [7:0] table_data;
  logic       router_reset;
  logic       busy;
  logic       err;

  int tests = 0;
  int fails = 0;

  // Spec-level model: expected outputs and table contents
  logic       exp_ack, exp_rr, exp_busy, exp_err;
  logic [7:0] model_mem [128];
  bit         chk_en = 1'b0;

  route_table_ctrl dut (
    .clk(clk), .reset(reset),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_last(cfg_last),
    .table_addr(table_addr), .table_data(table_data),
    .router_reset(router_reset), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // Compare process on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cfg_ack", 32'(cfg_ack), 32'(exp_ack));
      check("router_reset", 32'(router_reset), 32'(exp_rr));
      check("busy", 32'(busy), 32'(exp_busy));
      check("err", 32'(err), 32'(exp_err));
      check("table_data", 32'(table_data), 32'(model_mem[table_addr]));
    end
  end

  task automatic model_reset();
    exp_ack  = 1'b0;
    exp_rr   = 1'b1;
    exp_busy = 1'b1;
    exp_err  = 1'b0;
    for (int i = 0; i < 128; i++) model_mem[i] = 8'd0;
  endtask

  // Release reset just after an edge, then let INIT run its course
  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < INIT_CYC; k++) begin
      @(posedge clk); #1;
`ifdef ROUTE_TABLE_DEFAULT_EN
      model_mem[k] = 8'(k % 5);
`endif
    end
  endtask

  // One 4-phase write; called just after a clock edge with FSM in PROG (run=0) or RUN (run=1)
  task automatic host_write(input logic [6:0] a, input logic [7:0] d, input logic last,
                            input bit run, input int hold);
    cfg_addr = a;
    cfg_data = d;
    cfg_last = last;
    cfg_req  = 1'b1;
    @(posedge clk); #1;
    exp_ack  = 1'b1;
    exp_busy = 1'b1;
    if (d < 8'd5) model_mem[a] = d;
    else exp_err = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    cfg_req = 1'b0;
    @(posedge clk); #1;
    exp_ack = 1'b0;
    if (last && !run) begin
      exp_rr   = 1'b0;
      exp_busy = 1'b0;
    end else if (last) begin
      exp_rr   = 1'b1;
      exp_busy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_rr   = 1'b0;
      exp_busy = 1'b0;
    end else begin
      exp_busy = !run;
    end
  endtask

  logic [7:0] exp_0x10;

  initial begin
    reset      = 1'b1;
    cfg_req    = 1'b0;
    cfg_last   = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    table_addr = 7'h00;
    model_reset();
    #12;
    chk_en = 1'b1;

    // Reset state, literal
    check("rst_ack", 32'(cfg_ack), 32'd0);
    check("rst_router_reset", 32'(router_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tbl_00", 32'(table_data), 32'd0);
    table_addr = 7'h7F; #1;
    check("rst_tbl_7f", 32'(table_data), 32'd0);

    release_reset();

`ifdef ROUTE_TABLE_DEFAULT_EN
    table_addr = 7'h07; #1;
    check("dflt_tbl_07", 32'(table_data), 32'd2);
    table_addr = 7'h7F; #1;
    check("dflt_tbl_7f", 32'(table_data), 32'd2);
    exp_0x10 = 8'd1;
`else
    exp_0x10 = 8'd0;
`endif

    // Table programming in PROG, committing on the second write
    table_addr = 7'h05;
    host_write(7'h05, 8'd3, 1'b0, 1'b0, 0);
    table_addr = 7'h06;
    host_write(7'h06, 8'd1, 1'b1, 1'b0, 1);
    check("commit_rr_low", 32'(router_reset), 32'd0);
    check("commit_busy_low", 32'(busy), 32'd0);
    table_addr = 7'h05; #1;
    check("tbl_05", 32'(table_data), 32'd3);
    table_addr = 7'h06; #1;
    check("tbl_06", 32'(table_data), 32'd1);

    // Illegal entry in RUN: handshake completes, memory untouched, err sticky
    table_addr = 7'h10;
    host_write(7'h10, 8'd7, 1'b0, 1'b1, 0);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_mem", 32'(table_data), 32'(exp_0x10));
    table_addr = 7'h11;
    host_write(7'h11, 8'd4, 1'b0, 1'b1, 2);
    check("err_sticky", 32'(err), 32'd1);
    check("tbl_11", 32'(table_data), 32'd4);

    // Run-time commit: reload pulse of RELOAD_CYCLES
    table_addr = 7'h20;
    host_write(7'h20, 8'd2, 1'b1, 1'b1, 0);
    check("tbl_20", 32'(table_data), 32'd2);
    check("reload_done_rr", 32'(router_reset), 32'd0);
    repeat (3) begin @(posedge clk); #1; end

    // Reset asserted while in ACK with cfg_req still held
    table_addr = 7'h30;
    cfg_addr = 7'h30;
    cfg_data = 8'd4;
    cfg_last = 1'b0;
    cfg_req  = 1'b1;
    @(posedge clk); #1;
    exp_ack  = 1'b1;
    exp_busy = 1'b1;
    model_mem[7'h30] = 8'd4;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_ack", 32'(cfg_ack), 32'd0);
    check("mid_rst_rr", 32'(router_reset), 32'd1);
    check("mid_rst_err", 32'(err), 32'd0);
    release_reset();
    @(posedge clk); #1;
    exp_ack = 1'b1;
    model_mem[7'h30] = 8'd4;
    cfg_req = 1'b0;
    @(posedge clk); #1;
    exp_ack = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("once_ack", 32'(cfg_ack), 32'd0);
    check("once_rr", 32'(router_reset), 32'd1);
    check("once_tbl_30", 32'(table_data), 32'd4);

    // Sweep the read port over the whole table against the model
    for (int i = 0; i < 128; i++) begin
      table_addr = 7'(i);
      @(posedge clk); #1;
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
